// File: rtl/issue_pkg.sv
// Shared types and constants for the issue-queue select logic.
package issue_pkg;

  localparam int DEF_NUM_SLOTS = 8;
  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_LONG_LAT  = 4;

  localparam int IDX_W = $clog2(DEF_NUM_SLOTS);

  localparam logic LONG_LAT_CTRL = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } port_sel_t;

endpackage

// File: rtl/rr_port_picker.sv
// Rotating scan from rr_ptr that assigns requesting slots to ports.
module rr_port_picker
  import issue_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int IW        = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0]    request,
  input  logic [NUM_SLOTS-1:0]    ctrl,
  input  logic [IW-1:0]           ptr,
  input  logic                    busy,
  output logic [NUM_SLOTS-1:0]    grant,
  output logic [NUM_PORTS-1:0]    pvalid,
  output logic [NUM_PORTS*IW-1:0] pidx,
  output logic                    any_grant,
  output logic [IW-1:0]           last_idx,
  output logic                    long_grant
);

  logic [NUM_PORTS-1:0] taken;

  always_comb begin
    taken      = '0;
    taken[0]   = busy;
    grant      = '0;
    pvalid     = '0;
    pidx       = '0;
    any_grant  = 1'b0;
    last_idx   = '0;
    long_grant = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      int s;
      int pf;
      s  = int'(ptr) + k;
      if (s >= NUM_SLOTS) s = s - NUM_SLOTS;
      pf = -1;
      if (request[s]) begin
        if (ctrl[s] == LONG_LAT_CTRL) begin
          if (!taken[0]) pf = 0;
        end else begin
          for (int p = NUM_PORTS - 1; p >= 0; p--)
            if (!taken[p]) pf = p;
        end
      end
      if (pf >= 0) begin
        taken[pf]            = 1'b1;
        grant[s]             = 1'b1;
        pvalid[pf]           = 1'b1;
        pidx[pf*IW +: IW]    = IW'(s);
        any_grant            = 1'b1;
        last_idx             = IW'(s);
        if (pf == 0 && ctrl[s] == LONG_LAT_CTRL)
          long_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_select.sv
// Issue select: round-robin grant of slots to ports, port-0 busy tracking.
// Optional perf counters enabled by ISSUE_SELECT_PERF_EN.
module issue_select
  import issue_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int LONG_LAT  = DEF_LONG_LAT,
  localparam int IW       = $clog2(NUM_SLOTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SLOTS-1:0]    slot_request,
  input  logic [NUM_SLOTS-1:0]    slot_ctrl_info,
  input  logic                    flush,
  output logic [NUM_SLOTS-1:0]    slot_grant,
  output logic [NUM_PORTS-1:0]    port_valid,
  output logic [NUM_PORTS*IW-1:0] port_slot_idx,
`ifdef ISSUE_SELECT_PERF_EN
  output logic [31:0]             perf_issued,
  output logic [31:0]             perf_starved,
`endif
  output logic                    port0_busy
);

  localparam int BW = $clog2(LONG_LAT) + 1;
  localparam logic [BW-1:0] BUSY_LOAD = BW'(LONG_LAT - 1);

  logic [IW-1:0]           rr_ptr;
  logic [BW-1:0]           busy_cnt;
  logic [NUM_SLOTS-1:0]    pick_grant;
  logic [NUM_PORTS-1:0]    pick_valid;
  logic [NUM_PORTS*IW-1:0] pick_idx;
  logic                    any_grant;
  logic [IW-1:0]           last_idx;
  logic                    long_grant;
  logic [IW-1:0]           ptr_next;

  assign port0_busy = (busy_cnt != '0);

  rr_port_picker #(
    .NUM_SLOTS (NUM_SLOTS),
    .NUM_PORTS (NUM_PORTS),
    .IW        (IW)
  ) u_picker (
    .request    (slot_request),
    .ctrl       (slot_ctrl_info),
    .ptr        (rr_ptr),
    .busy       (port0_busy),
    .grant      (pick_grant),
    .pvalid     (pick_valid),
    .pidx       (pick_idx),
    .any_grant  (any_grant),
    .last_idx   (last_idx),
    .long_grant (long_grant)
  );

  // A flush kills everything the picker produced this cycle.
  assign slot_grant    = flush ? '0 : pick_grant;
  assign port_valid    = flush ? '0 : pick_valid;
  assign port_slot_idx = flush ? '0 : pick_idx;

  assign ptr_next = (int'(last_idx) == NUM_SLOTS - 1) ? '0
                  : last_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      busy_cnt <= '0;
    end else if (flush) begin
      rr_ptr   <= '0;
      busy_cnt <= '0;
    end else begin
      if (any_grant)
        rr_ptr <= ptr_next;
      if (long_grant)
        busy_cnt <= BUSY_LOAD;
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - BW'(1);
    end
  end

`ifdef ISSUE_SELECT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued  <= '0;
      perf_starved <= '0;
    end else begin
      perf_issued <= perf_issued + 32'($countones(port_valid));
      if (!flush && slot_request != '0 && !any_grant)
        perf_starved <= perf_starved + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_select.sv
// Directed-vector bench for issue_select (default parameters).
// Perf counter checks are active when ISSUE_SELECT_PERF_EN is defined.
module tb_issue_select;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] slot_request;
  logic [7:0] slot_ctrl_info;
  logic       flush;
  logic [7:0] slot_grant;
  logic [1:0] port_valid;
  logic [5:0] port_slot_idx;
  logic       port0_busy;
`ifdef ISSUE_SELECT_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_starved;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  issue_select dut (
    .clk            (clk),
    .reset          (reset),
    .slot_request   (slot_request),
    .slot_ctrl_info (slot_ctrl_info),
    .flush          (flush),
    .slot_grant     (slot_grant),
    .port_valid     (port_valid),
    .port_slot_idx  (port_slot_idx),
`ifdef ISSUE_SELECT_PERF_EN
    .perf_issued    (perf_issued),
    .perf_starved   (perf_starved),
`endif
    .port0_busy     (port0_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] c,
                       input logic f);
    slot_request   = r;
    slot_ctrl_info = c;
    flush          = f;
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(8'h00, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    #2;
    vecs++;
    if (port0_busy !== 1'b0) begin
      errs++; $display("FAIL rst_busy got %b exp 0", port0_busy);
    end
    vecs++;
    if (dut.rr_ptr !== 3'd0) begin
      errs++; $display("FAIL rst_ptr got %0d exp 0", dut.rr_ptr);
    end
    vecs++;
    if (slot_grant !== 8'h00 || port_valid !== 2'b00) begin
      errs++; $display("FAIL rst_grant got %h/%b exp 00/00",
                       slot_grant, port_valid);
    end
  endtask

  task automatic test_basic();
    drive(8'b0000_1111, 8'h00, 1'b0);
    vecs++;
    if (slot_grant !== 8'b0000_0011 || port_valid !== 2'b11 ||
        port_slot_idx !== 6'b001_000) begin
      errs++; $display("FAIL basic_c0 got %b %b %b exp 00000011 11 001000",
                       slot_grant, port_valid, port_slot_idx);
    end
    tick();
    vecs++;
    if (slot_grant !== 8'b0000_1100 || port_slot_idx !== 6'b011_010) begin
      errs++; $display("FAIL basic_c1 got %b %b exp 00001100 011010",
                       slot_grant, port_slot_idx);
    end
    tick();
    drive(8'h00, 8'h00, 1'b0);
    vecs++;
    if (dut.rr_ptr !== 3'd4) begin
      errs++; $display("FAIL basic_ptr got %0d exp 4", dut.rr_ptr);
    end
  endtask

  task automatic test_wrap();
    drive(8'b0011_0000, 8'h00, 1'b0);
    tick();
    drive(8'b1000_0010, 8'h00, 1'b0);
    vecs++;
    if (dut.rr_ptr !== 3'd6) begin
      errs++; $display("FAIL wrap_pre got %0d exp 6", dut.rr_ptr);
    end
    vecs++;
    if (slot_grant !== 8'b1000_0010 || port_valid !== 2'b11 ||
        port_slot_idx !== 6'b001_111) begin
      errs++; $display("FAIL wrap_grant got %b %b %b exp 10000010 11 001111",
                       slot_grant, port_valid, port_slot_idx);
    end
    tick();
    drive(8'h00, 8'h00, 1'b0);
    vecs++;
    if (dut.rr_ptr !== 3'd2) begin
      errs++; $display("FAIL wrap_ptr got %0d exp 2", dut.rr_ptr);
    end
  endtask

  task automatic test_long_lat();
    drive(8'b0000_1000, 8'b0000_1000, 1'b0);
    vecs++;
    if (slot_grant !== 8'b0000_1000 || port_valid !== 2'b01 ||
        port_slot_idx !== 6'b000_011) begin
      errs++; $display("FAIL long_issue got %b %b %b exp 00001000 01 000011",
                       slot_grant, port_valid, port_slot_idx);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(8'b0110_0000, 8'b0010_0000, 1'b0);
      vecs++;
      if (port0_busy !== 1'b1) begin
        errs++; $display("FAIL long_busy%0d got %b exp 1", i, port0_busy);
      end
      vecs++;
      if (slot_grant !== 8'b0100_0000 || port_valid !== 2'b10 ||
          port_slot_idx !== 6'b110_000) begin
        errs++; $display("FAIL long_win%0d got %b %b %b exp 01000000 10 110000",
                         i, slot_grant, port_valid, port_slot_idx);
      end
    end
    tick();
    vecs++;
    if (port0_busy !== 1'b0) begin
      errs++; $display("FAIL long_free got %b exp 0", port0_busy);
    end
    vecs++;
    if (slot_grant !== 8'b0110_0000 || port_valid !== 2'b11 ||
        port_slot_idx !== 6'b110_101) begin
      errs++; $display("FAIL long_c4 got %b %b %b exp 01100000 11 110101",
                       slot_grant, port_valid, port_slot_idx);
    end
  endtask

  task automatic test_flush();
    tick();
    drive(8'h00, 8'h00, 1'b0);
    tick();
    drive(8'hFF, 8'h00, 1'b1);
    vecs++;
    if (port0_busy !== 1'b1) begin
      errs++; $display("FAIL flush_pre got %b exp 1", port0_busy);
    end
    vecs++;
    if (slot_grant !== 8'h00 || port_valid !== 2'b00 ||
        port_slot_idx !== 6'd0) begin
      errs++; $display("FAIL flush_kill got %b %b %b exp 0 0 0",
                       slot_grant, port_valid, port_slot_idx);
    end
    tick();
    drive(8'h00, 8'h00, 1'b0);
    vecs++;
    if (port0_busy !== 1'b0 || dut.rr_ptr !== 3'd0) begin
      errs++; $display("FAIL flush_after got busy=%b ptr=%0d exp 0 0",
                       port0_busy, dut.rr_ptr);
    end
  endtask

  task automatic test_mixed_order();
    drive(8'b0000_0011, 8'b0000_0010, 1'b0);
    vecs++;
    if (slot_grant !== 8'b0000_0001 || port_valid !== 2'b01 ||
        port_slot_idx !== 6'd0) begin
      errs++; $display("FAIL mixed_c0 got %b %b %b exp 00000001 01 000000",
                       slot_grant, port_valid, port_slot_idx);
    end
    tick();
    drive(8'b0000_0010, 8'b0000_0010, 1'b0);
    vecs++;
    if (slot_grant !== 8'b0000_0010 || port_valid !== 2'b01 ||
        port_slot_idx !== 6'b000_001) begin
      errs++; $display("FAIL mixed_c1 got %b %b %b exp 00000010 01 000001",
                       slot_grant, port_valid, port_slot_idx);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    drive(8'h00, 8'h00, 1'b0);
    tick(); tick(); tick();
    drive(8'b0000_1000, 8'h00, 1'b0);
    vecs++;
    if (port_slot_idx !== 6'b000_011 || port_valid !== 2'b01) begin
      errs++; $display("FAIL mid_setup got %b %b exp 000011 01",
                       port_slot_idx, port_valid);
    end
    tick();
    drive(8'b0001_0000, 8'b0001_0000, 1'b0);
    tick();
    drive(8'hFF, 8'h00, 1'b1);
    vecs++;
    if (dut.busy_cnt !== 3'd3 || dut.rr_ptr !== 3'd5) begin
      errs++; $display("FAIL mid_pre got busy=%0d ptr=%0d exp 3 5",
                       dut.busy_cnt, dut.rr_ptr);
    end
    reset = 1'b1;
    drive(8'hFF, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    drive(8'h00, 8'h00, 1'b0);
    vecs++;
    if (dut.busy_cnt !== 3'd0 || dut.rr_ptr !== 3'd0 ||
        port0_busy !== 1'b0) begin
      errs++; $display("FAIL mid_rst got busy=%0d ptr=%0d p0=%b exp 0 0 0",
                       dut.busy_cnt, dut.rr_ptr, port0_busy);
    end
`ifdef ISSUE_SELECT_PERF_EN
    vecs++;
    if (perf_issued !== 32'd0 || perf_starved !== 32'd0) begin
      errs++; $display("FAIL perf_rst got %0d %0d exp 0 0",
                       perf_issued, perf_starved);
    end
`endif
  endtask

  task automatic test_back_to_back();
    drive(8'hFF, 8'h00, 1'b0);
    vecs++;
    if (slot_grant !== 8'b0000_0011 || port_valid !== 2'b11) begin
      errs++; $display("FAIL b2b_first got %b %b exp 00000011 11",
                       slot_grant, port_valid);
    end
    for (int i = 0; i < 10; i++) tick();
    drive(8'h00, 8'h00, 1'b0);
    vecs++;
    if (dut.rr_ptr !== 3'd4) begin
      errs++; $display("FAIL b2b_ptr got %0d exp 4", dut.rr_ptr);
    end
`ifdef ISSUE_SELECT_PERF_EN
    vecs++;
    if (perf_issued !== 32'd20) begin
      errs++; $display("FAIL perf_issued got %0d exp 20", perf_issued);
    end
    vecs++;
    if (perf_starved !== 32'd0) begin
      errs++; $display("FAIL perf_starved got %0d exp 0", perf_starved);
    end
`endif
  endtask

  initial begin
    reset          = 1'b1;
    slot_request   = '0;
    slot_ctrl_info = '0;
    flush          = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_long_lat();
    test_flush();
    test_mixed_order();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
